// File: rtl/index_stream_decoder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : index_stream_decoder_pkg
//  Description : Shared state encoding and width helpers for the index
//                stream decoder and its priority encoder.
//  Revision    : 1.0  initial release
// ============================================================================
package index_stream_decoder_pkg;

    // Two-state controller: gathering beats, or presenting a finished vector
    localparam logic [0:0] ST_ACCUM  = 1'b0;
    localparam logic [0:0] ST_OUTPUT = 1'b1;

    // Bits needed to encode an index into a WIDTH-bit vector (never zero)
    function automatic int idx_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    // Bits needed to hold a population count from 0 to WIDTH inclusive
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/priority_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : priority_encoder
//  Description : Returns the lowest set bit index of a vector and whether
//                any bit is set. Index is zero when the vector is empty.
//  Revision    : 1.0  initial release
// ============================================================================
module priority_encoder
    import index_stream_decoder_pkg::*;
#(
    parameter int WIDTH = 32
)
(
    input  logic [WIDTH-1:0]            i_unencoded,
    output logic [idx_width(WIDTH)-1:0] o_encoded,
    output logic                        o_any
);

    localparam int c_idx_w = idx_width(WIDTH);

    // Scan from the top down so the lowest set bit is the last one written
    always_comb begin
        o_encoded = '0;
        o_any     = |i_unencoded;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (i_unencoded[i]) begin
                o_encoded = c_idx_w'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/index_stream_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : index_stream_decoder
//  Description : OR-accumulates a stream of encoded bit indices into a
//                WIDTH-bit mask, closed by s_last, and hands the completed
//                mask downstream with ready/valid flow control. Tracks the
//                number of distinct bits, repeated indices and out-of-range
//                indices.
//  Revision    : 1.0  initial release
// ============================================================================
module index_stream_decoder
    import index_stream_decoder_pkg::*;
#(
    parameter int WIDTH = 32
)
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic [idx_width(WIDTH)-1:0] s_index,
    input  logic                        s_valid,
    input  logic                        s_last,
    output logic                        s_ready,
    output logic [WIDTH-1:0]            m_unencoded,
    output logic [cnt_width(WIDTH)-1:0] m_count,
    output logic [idx_width(WIDTH)-1:0] m_encoded,
    output logic                        m_any,
    output logic                        m_duplicate,
    output logic                        m_error,
    output logic                        m_valid,
    input  logic                        m_ready
);

    localparam int              c_cnt_w = cnt_width(WIDTH);
    localparam logic [WIDTH-1:0] c_lsb  = WIDTH'(1);

    logic [0:0]         r_state;
    logic [WIDTH-1:0]   r_vec;
    logic [c_cnt_w-1:0] r_count;
    logic               r_dup;
    logic               r_err;

    logic               w_in_range;
    logic [WIDTH-1:0]   w_bit;
    logic               w_new;
    logic               w_hit;

    // Decode the incoming index and compare it against what is already held
    always_comb begin
        w_in_range = (int'(s_index) < WIDTH);
        w_bit      = w_in_range ? (c_lsb << s_index) : '0;
        w_new      = |(w_bit & ~r_vec);
        w_hit      = |(w_bit & r_vec);
    end

    // Controller, accumulator, distinct-bit count and sticky flags
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_ACCUM;
            r_vec   <= '0;
            r_count <= '0;
            r_dup   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_ACCUM: begin
                    if (s_valid) begin
                        r_vec <= r_vec | w_bit;
                        if (w_new) begin
                            r_count <= r_count + c_cnt_w'(1);
                        end
                        if (w_hit) begin
                            r_dup <= 1'b1;
                        end
                        // Out-of-range beats still close the vector
                        if (!w_in_range) begin
                            r_err <= 1'b1;
                        end
                        if (s_last) begin
                            r_state <= ST_OUTPUT;
                        end
                    end
                end
                ST_OUTPUT: begin
                    if (m_ready) begin
                        r_vec   <= '0;
                        r_count <= '0;
                        r_dup   <= 1'b0;
                        r_err   <= 1'b0;
                        r_state <= ST_ACCUM;
                    end
                end
                default: begin
                    r_state <= ST_ACCUM;
                end
            endcase
        end
    end

    // Handshake signals depend on the state register only
    assign s_ready     = (r_state == ST_ACCUM);
    assign m_valid     = (r_state == ST_OUTPUT);
    assign m_unencoded = r_vec;
    assign m_count     = r_count;
    assign m_duplicate = r_dup;
    assign m_error     = r_err;

    priority_encoder #(
        .WIDTH (WIDTH)
    ) u_priority_encoder (
        .i_unencoded (r_vec),
        .o_encoded   (m_encoded),
        .o_any       (m_any)
    );

endmodule
`default_nettype wire
